// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch constants and state type
package cpu_pkg;

    localparam int                  PC_W      = 8;
    localparam logic [PC_W-1:0]     RESET_PC  = 8'h00;
    localparam int                  INSTR_W   = 32;
    localparam logic [INSTR_W-1:0]  HALT_WORD = 32'h0000_0000;
    localparam int                  PC_STEP   = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if_id_reg.sv
// rtl/ifetch_unit_if_id_reg.sv - IF/ID pipeline register with hold and bubble controls
module if_id_reg #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    // A bubble only drops valid; the stale payload is never consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!hold) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: PC ownership, redirect, stall, halt and error trap
module ifetch_unit #(
    parameter int                          PC_W      = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0]             RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [cpu_pkg::INSTR_W-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          IF_stall,
    input  logic                          IF_redirect,
    input  logic [PC_W-1:0]               IF_redirect_pc,
    output logic [PC_W-1:0]               IF_imem_pc,
    input  logic [cpu_pkg::INSTR_W-1:0]   IF_imem_instruction,
    output logic [cpu_pkg::INSTR_W-1:0]   IF_instr,
    output logic [PC_W-1:0]               IF_pc,
    output logic                          IF_valid,
    output logic                          IF_halted,
    output logic                          IF_err
);
    import cpu_pkg::*;

    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            misaligned;
    logic            halt_hit;
    logic            reg_hold;
    logic            reg_clear;

    assign misaligned = IF_redirect_pc[1:0] != 2'b00;
    assign halt_hit   = IF_imem_instruction == HALT_WORD;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        reg_hold  = 1'b0;
        reg_clear = 1'b1;
        case (state)
            ST_BOOT, ST_HALT: begin
                if (IF_redirect) begin
                    if (misaligned) begin
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_RUN;
                        pc_nxt    = IF_redirect_pc;
                    end
                end else if (state == ST_BOOT) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (IF_redirect) begin
                    if (misaligned) begin
                        state_nxt = ST_ERR;
                    end else begin
                        pc_nxt = IF_redirect_pc;
                    end
                end else if (IF_stall) begin
                    reg_clear = 1'b0;
                    reg_hold  = 1'b1;
                end else if (halt_hit) begin
                    state_nxt = ST_HALT;
                end else begin
                    reg_clear = 1'b0;
                    pc_nxt    = pc + PC_W'(PC_STEP);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (reg_hold),
        .clear    (reg_clear),
        .instr_in (IF_imem_instruction),
        .pc_in    (pc),
        .instr    (IF_instr),
        .pc       (IF_pc),
        .valid    (IF_valid)
    );

    assign IF_imem_pc = pc;
    assign IF_halted  = state == ST_HALT;
    assign IF_err     = state == ST_ERR;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit against a behavioural fetch model
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_pc;
    logic [31:0] imem_instruction;
    logic [31:0] instr;
    logic [7:0]  ipc;
    logic        valid;
    logic        halted;
    logic        err;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_pc[7:2]];

    ifetch_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .IF_stall            (stall),
        .IF_redirect         (redirect),
        .IF_redirect_pc      (redirect_pc),
        .IF_imem_pc          (imem_pc),
        .IF_imem_instruction (imem_instruction),
        .IF_instr            (instr),
        .IF_pc               (ipc),
        .IF_valid            (valid),
        .IF_halted           (halted),
        .IF_err              (err)
    );

    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;
    localparam int MODE_ERR  = 3;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_mode;
    int          m_pc;
    int          m_ipc;
    logic [31:0] m_instr;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = MODE_BOOT;
        m_pc    = 0;
        m_ipc   = 0;
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_redirect();
        m_valid = 1'b0;
        if (int'(redirect_pc) % 4 != 0) begin
            m_mode = MODE_ERR;
        end else begin
            m_pc   = int'(redirect_pc);
            m_mode = MODE_RUN;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_mode == MODE_BOOT) begin
            if (redirect) model_redirect();
            else          m_mode = MODE_RUN;
        end else if (m_mode == MODE_HALT) begin
            if (redirect) model_redirect();
        end else if (m_mode == MODE_RUN) begin
            if (redirect) begin
                model_redirect();
            end else if (!stall) begin
                if (mem[m_pc / 4] == 32'h0) begin
                    m_mode  = MODE_HALT;
                    m_valid = 1'b0;
                end else begin
                    m_instr = mem[m_pc / 4];
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = (m_pc + 4) % 256;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_pc", {24'h0, imem_pc}, m_pc);
        chk("valid", {31'h0, valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("if_pc", {24'h0, ipc}, m_ipc);
        end
        chk("halted", {31'h0, halted}, (m_mode == MODE_HALT) ? 1 : 0);
        chk("err", {31'h0, err}, (m_mode == MODE_ERR) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic fill_nonzero();
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | (32'(i) << 8) | 32'h5;
    endtask

    int   wrapped;
    int   prev_ipc;
    int   saved_pc;

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        fill_nonzero();
        model_reset();

        // sequential fetch into halt word
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h0000_0000;
        #1;
        chk("reset_valid", {31'h0, valid}, 0);
        chk("reset_pc", {24'h0, imem_pc}, 0);
        do_reset();
        step();
        chk("boot_valid", {31'h0, valid}, 0);
        step();
        chk("seq0_instr", instr, 32'h1111_1111);
        chk("seq0_pc", {24'h0, ipc}, 32'h00);
        step();
        chk("seq1_instr", instr, 32'h2222_2222);
        step();
        chk("seq2_instr", instr, 32'h3333_3333);
        chk("seq2_pc", {24'h0, ipc}, 32'h08);
        step();
        chk("halt_flag", {31'h0, halted}, 1);
        chk("halt_pc", {24'h0, imem_pc}, 32'h0C);

        // stall freezes everything
        do_reset();
        step();
        step();
        stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_instr", instr, 32'h1111_1111);
            chk("stall_pc", {24'h0, imem_pc}, 32'h04);
        end
        stall = 1'b0;
        step();
        chk("unstall_instr", instr, 32'h2222_2222);
        chk("unstall_pc", {24'h0, ipc}, 32'h04);

        // redirect overrides stall, one bubble
        mem[8]      = 32'hABCD_0008;
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        stall       = 1'b1;
        step();
        chk("redir_bubble", {31'h0, valid}, 0);
        chk("redir_pc", {24'h0, imem_pc}, 32'h20);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        chk("redir_instr", instr, 32'hABCD_0008);
        chk("redir_ifpc", {24'h0, ipc}, 32'h20);

        // wrap FC -> 00
        fill_nonzero();
        do_reset();
        wrapped  = 0;
        prev_ipc = -1;
        repeat (70) begin
            step();
            if (valid) begin
                if (prev_ipc == 32'hFC && ipc == 8'h00) wrapped = 1;
                prev_ipc = int'(ipc);
            end
        end
        chk("wrap_seen", wrapped, 1);
        chk("wrap_not_halted", {31'h0, halted}, 0);

        // misaligned redirect trap, sticky, async clear
        redirect    = 1'b1;
        redirect_pc = 8'h22;
        step();
        chk("err_set", {31'h0, err}, 1);
        chk("err_valid", {31'h0, valid}, 0);
        saved_pc    = int'(imem_pc);
        redirect_pc = 8'h20;
        step();
        chk("err_sticky_pc", {24'h0, imem_pc}, saved_pc);
        chk("err_sticky", {31'h0, err}, 1);
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("err_async_clear", {31'h0, err}, 0);
        step();
        rst_n = 1'b1;

        // async reset mid-cycle at PC=10
        step();
        repeat (4) step();
        chk("pre_rst_pc", {24'h0, imem_pc}, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_instr", instr, 0);
        chk("async_ifpc", {24'h0, ipc}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("restart_boot", {31'h0, valid}, 0);
        step();
        chk("restart_ifpc", {24'h0, ipc}, 0);
        chk("restart_valid", {31'h0, valid}, 1);

        // randomized traffic against the model
        for (int i = 0; i < 64; i++) mem[i] = ($urandom % 16 == 0) ? 32'h0 : ($urandom | 32'h1);
        for (int c = 0; c < 3000; c++) begin
            rst_n    = ($urandom % 200 != 0);
            stall    = ($urandom % 4 == 0);
            redirect = ($urandom % 8 == 0);
            redirect_pc = 8'($urandom);
            if ($urandom % 10 != 0) redirect_pc[1:0] = 2'b00;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
